// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Index width for n items; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set req bit starting at ptr.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int ID_W      = id_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic                 valid,
  output logic [ID_W-1:0]      winner
);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;

  // rot[i] == req[(ptr+i) mod NUM_PORTS]; scan downward so the lowest offset wins.
  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[NUM_PORTS-1:0];
    valid  = |rot;
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) winner = ID_W'((int'(ptr) + i) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with multi-cycle ownership: grant held until done,
// request drop, or hold timeout.
module rr_hold_arbiter
  import arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int MAX_HOLD  = 16,
  localparam int ID_W      = id_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] done,
  output logic [NUM_PORTS-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout,
  output logic [ID_W-1:0]      timeout_id
);

  localparam int              CNT_W     = id_w(MAX_HOLD + 1);
  localparam bit              TO_EN     = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e           state, state_n;
  logic [ID_W-1:0]      ptr, ptr_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [NUM_PORTS-1:0] grant_n;
  logic [ID_W-1:0]      grant_id_n, timeout_id_n;
  logic                 timeout_n;
  logic                 pick_vld;
  logic [ID_W-1:0]      pick_id;
  logic                 owner_done, owner_req;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_vld),
    .winner (pick_id)
  );

  // grant is one-hot, so masking isolates the owner's bits.
  assign owner_done = |(done & grant);
  assign owner_req  = |(req & grant);
  assign busy       = |grant;

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    grant_id_n   = grant_id;
    ptr_n        = ptr;
    cnt_n        = cnt;
    timeout_n    = 1'b0;
    timeout_id_n = timeout_id;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_n    = NUM_PORTS'(1) << pick_id;
          grant_id_n = pick_id;
          ptr_n      = (int'(pick_id) == NUM_PORTS - 1) ? '0 : pick_id + ID_W'(1);
          cnt_n      = '0;
          state_n    = HOLD;
        end
      end
      HOLD: begin
        if (owner_done || !owner_req) begin
          grant_n = '0;
          state_n = IDLE;
        end else if (TO_EN && cnt == HOLD_LAST) begin
          grant_n      = '0;
          timeout_n    = 1'b1;
          timeout_id_n = grant_id;
          state_n      = IDLE;
        end else if (TO_EN) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      ptr        <= '0;
      cnt        <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      grant_id   <= grant_id_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      timeout    <= timeout_n;
      timeout_id <= timeout_id_n;
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (NUM_PORTS=4, MAX_HOLD=16).
module tb_rr_hold_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  logic [1:0] timeout_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] gid;
    logic       busy;
    logic       to;
    logic [1:0] tid;
  } vec_t;

  vec_t vecs[13];

  rr_hold_arbiter #(.NUM_PORTS(4), .MAX_HOLD(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  always #5 clk = ~clk;

  // timeout_id is only compared when a timeout pulse is expected.
  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb, input logic eto, input logic [1:0] etid);
    logic [1:0] atid;
    atid = eto ? timeout_id : etid;
    checks++;
    if ({grant, grant_id, busy, timeout, atid} !== {eg, eid, eb, eto, etid}) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b to=%b tid=%0d, want grant=%b id=%0d busy=%b to=%b tid=%0d",
               name, grant, grant_id, busy, timeout, timeout_id, eg, eid, eb, eto, etid);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    done = '0;
    #1;
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{4'b0111, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{4'b0011, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{4'b1010, 4'b1001, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{4'b0000, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd0};

    #3;
    check("reset_initial", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    #9;
    rst = 1'b0;

    // Table: grant/release, abandon, pointer wrap, ignored done bits.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].gid, vecs[i].busy, vecs[i].to, vecs[i].tid);
    end

    // Round robin with all ports requesting, each holds 3 cycles.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] own;
      logic [3:0] oh;
      own = 2'(k % 4);
      oh  = 4'b0001 << own;
      for (int c = 0; c < 3; c++) begin
        step(4'b1111, 4'b0000);
        check($sformatf("rr_own%0d_c%0d", k, c), oh, own, 1'b1, 1'b0, 2'd0);
      end
      step(4'b1111, oh);
      check($sformatf("rr_rel%0d", k), 4'b0000, own, 1'b0, 1'b0, 2'd0);
    end

    // Timeout: port 2 holds for exactly 16 cycles, then forced off.
    for (int c = 0; c < 16; c++) begin
      step(4'b0100, 4'b0000);
      check($sformatf("to_hold%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
    end
    step(4'b0100, 4'b0000);
    check("to_pulse", 4'b0000, 2'd2, 1'b0, 1'b1, 2'd2);
    step(4'b1100, 4'b0000);
    check("to_next_port3", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    step(4'b1100, 4'b1000);
    check("to_port3_rel", 4'b0000, 2'd3, 1'b0, 1'b0, 2'd0);

    // done coincides with the timeout threshold: done wins.
    for (int c = 0; c < 16; c++) begin
      step(4'b0010, 4'b0000);
      check($sformatf("dt_hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
    end
    step(4'b0010, 4'b0010);
    check("dt_release", 4'b0000, 2'd1, 1'b0, 1'b0, 2'd0);
    step(4'b0000, 4'b0000);
    check("dt_no_pulse", 4'b0000, 2'd1, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset mid-hold, then pointer restarts at 0.
    step(4'b0001, 4'b0000);
    check("ar_grant", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
    step(4'b0001, 4'b0000);
    check("ar_hold", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async_drop", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    req = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    step(4'b1001, 4'b0000);
    check("ar_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
Round-robin arbiter for one shared resource with multi-cycle ownership. A requester keeps its grant until it signals done, drops its request, or exceeds a hold timeout. It sits in front of a shared datapath resource (bus port, memory bank, engine) and replaces single-cycle grant arbitration wherever a transaction spans several cycles.

Parameters:
NUM_PORTS, 4, number of requesters (>=2)
MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout
ID_W, $clog2(NUM_PORTS), width of port index outputs (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  NUM_PORTS  per-port request, level
done  input  NUM_PORTS  per-port end-of-ownership strobe; only the granted port's bit is honoured
grant  output  NUM_PORTS  one-hot grant, registered
grant_id  output  ID_W  binary index of the current/last grantee, registered
busy  output  1  high while any grant is held (equals |grant)
timeout  output  1  single-cycle pulse when a hold is forcibly ended
timeout_id  output  ID_W  port whose hold timed out; valid when timeout=1

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: grant=0, grant_id=0, busy=0, timeout=0, timeout_id=0, priority pointer=0, hold counter=0, state=IDLE. rst asserted mid-hold drops grant immediately (asynchronously) with no timeout pulse.
- States: IDLE, HOLD.
- IDLE: if |req at a rising edge, the winner is the first set req bit scanning ptr, ptr+1, ... mod NUM_PORTS. Same edge: grant <= onehot(winner), grant_id <= winner, ptr <= (winner+1) mod NUM_PORTS, hold counter <= 0, state <= HOLD. Latency: req seen at edge t gives grant visible after edge t (1 cycle). No req: remain IDLE with grant=0.
- HOLD: grant and grant_id stay stable. Each edge evaluates, in priority order:
  1) done[grant_id]=1: release; grant <= 0, state <= IDLE, no timeout.
  2) req[grant_id]=0: abandon; treated the same as release.
  3) MAX_HOLD>0 and hold counter == MAX_HOLD-1: forced release; grant <= 0, timeout <= 1 for one cycle, timeout_id <= grant_id, state <= IDLE.
  4) Otherwise: hold counter increments.
- done bits of non-granted ports are ignored in every state. done in IDLE is ignored.
- Release always inserts exactly one grant-free cycle before the next grant, so back-to-back owners are separated by one idle cycle.
- Grant duration is at most MAX_HOLD cycles. Hold counter width is $clog2(MAX_HOLD+1), minimum 1. With MAX_HOLD=0 the counter is held at 0.
- Pointer advances only on grant issue, never on release or timeout. A timed-out port therefore has lowest priority at the next arbitration.
- Simultaneous done and timeout-threshold on the same edge: done wins, no timeout pulse.
- grant is always one-hot or zero. grant_id retains the last grantee while IDLE.

Decomposition:
- Shared package arbiter_pkg: state enum (IDLE, HOLD); id-width helper function (clog2 with minimum 1).
- One sub-module rr_pick: combinational circular priority picker. Inputs: req vector and ptr. Outputs: valid and winner index. Reusable by other round-robin arbiters in the library.

Test Plan:
- Reset, then req=4'b0101 held, ptr=0 -> after 1 edge grant=0001, grant_id=0; done[0] pulse -> grant=0 for 1 cycle, then grant=0100.
- All four req held; each owner pulses done after 3 cycles -> grant order 0,1,2,3,0 with one idle cycle between owners; busy tracks |grant.
- MAX_HOLD=16, req[2] held, done never asserted -> grant=0100 for exactly 16 cycles, then timeout=1 for 1 cycle with timeout_id=2; next winner is port 3 if requesting.
- Port 1 granted, done[3] and done[0] pulsed -> ignored, grant stays 0010. Then req[1] deasserts -> grant drops next edge, no timeout.
- done[grant_id] asserted on the same edge the counter hits MAX_HOLD-1 -> release, timeout stays 0.
- rst asserted mid-hold between clock edges -> grant=0, busy=0 immediately; after deassert, first grant goes to the lowest-index requester (ptr=0).
